// File: rtl/wb_mtimer_pkg.sv
// ----------------------------------------------------------------------------
// wb_mtimer_pkg : register map and CTRL bit layout for wb_mtimer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wb_mtimer_pkg;

  // Per-channel register select, taken from wb_adr_i[3:2]
  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COMPARE = 2'd1,
    REG_COUNTER = 2'd2,
    REG_RSVD    = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_CLR   = 3;
  localparam int CTRL_PEND  = 4;

  localparam int         DEC_W           = 7;       // wb_adr_i[8:2]
  localparam logic [DEC_W-1:0] IRQ_STATUS_WADR = 7'h40;   // byte 0x100

endpackage

`default_nettype wire

// File: rtl/wb_mtimer_chan.sv
// ----------------------------------------------------------------------------
// wb_mtimer_chan : one timer channel (CTRL, COMPARE, COUNTER, match). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_mtimer_chan
  import wb_mtimer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             we_ctrl,
  input  logic             we_compare,
  input  logic             we_counter,
  input  logic             pend_clr,
  input  logic [WIDTH-1:0] wdata,
  output logic [31:0]      ctrl_rd,
  output logic [31:0]      compare_rd,
  output logic [31:0]      counter_rd,
  output logic             pend,
  output logic             irq
);

  logic             r_en;
  logic             r_ar;
  logic             r_irqen;
  logic             r_pend;
  logic [WIDTH-1:0] r_compare;
  logic [WIDTH-1:0] r_counter;

  logic w_run;
  logic w_match;

  assign w_run   = tick & r_en;
  assign w_match = w_run & (r_counter == r_compare);

  // Bus writes are placed after the hardware update so they take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_ar      <= 1'b0;
      r_irqen   <= 1'b0;
      r_pend    <= 1'b0;
      r_compare <= '0;
      r_counter <= '0;
    end else begin
      if (w_match) begin
        if (r_ar) r_counter <= '0;
        else      r_en      <= 1'b0;
      end else if (w_run) begin
        r_counter <= r_counter + WIDTH'(1);
      end

      if (we_ctrl) begin
        r_en    <= wdata[CTRL_EN];
        r_ar    <= wdata[CTRL_AR];
        r_irqen <= wdata[CTRL_IRQEN];
        if (wdata[CTRL_CLR]) r_counter <= '0;
      end
      if (we_compare) r_compare <= wdata;
      if (we_counter) r_counter <= wdata;

      if (w_match)       r_pend <= 1'b1;
      else if (pend_clr) r_pend <= 1'b0;
    end
  end

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[CTRL_EN]    = r_en;
    ctrl_rd[CTRL_AR]    = r_ar;
    ctrl_rd[CTRL_IRQEN] = r_irqen;
    ctrl_rd[CTRL_PEND]  = r_pend;
  end

  assign compare_rd = 32'(r_compare);
  assign counter_rd = 32'(r_counter);
  assign pend       = r_pend;
  assign irq        = r_pend & r_irqen;

endmodule

`default_nettype wire

// File: rtl/wb_mtimer.sv
// ----------------------------------------------------------------------------
// wb_mtimer : Wishbone multi-channel timer/compare unit with prescaler. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  output logic                wb_ack_o,
  output logic [CHANNELS-1:0] intr
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  logic     w_access;
  logic     w_wr;
  logic     w_chan_space;
  logic     w_status_hit;
  logic [3:0] w_chan;
  reg_sel_e w_reg;
  logic     w_unused;

  assign w_access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign w_wr         = w_access & wb_we_i & (wb_sel_i == 4'hF);
  assign w_chan       = wb_adr_i[7:4];
  assign w_reg        = reg_sel_e'(wb_adr_i[3:2]);
  assign w_chan_space = ~wb_adr_i[8];
  assign w_status_hit = (wb_adr_i[8:2] == IRQ_STATUS_WADR);
  assign w_unused     = ^{wb_adr_i[31:9], wb_adr_i[1:0], wb_dat_i};

  logic [31:0]         w_ctrl_rd    [CHANNELS];
  logic [31:0]         w_compare_rd [CHANNELS];
  logic [31:0]         w_counter_rd [CHANNELS];
  logic [CHANNELS-1:0] w_pend;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic w_hit;
      assign w_hit = w_wr & w_chan_space & (w_chan == 4'(i));

      wb_mtimer_chan #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .tick       (w_tick),
        .we_ctrl    (w_hit & (w_reg == REG_CTRL)),
        .we_compare (w_hit & (w_reg == REG_COMPARE)),
        .we_counter (w_hit & (w_reg == REG_COUNTER)),
        .pend_clr   ((w_hit & (w_reg == REG_CTRL) & wb_dat_i[CTRL_PEND]) |
                     (w_wr & w_status_hit & wb_dat_i[i])),
        .wdata      (wb_dat_i[WIDTH-1:0]),
        .ctrl_rd    (w_ctrl_rd[i]),
        .compare_rd (w_compare_rd[i]),
        .counter_rd (w_counter_rd[i]),
        .pend       (w_pend[i]),
        .irq        (intr[i])
      );
    end
  endgenerate

  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_status_hit) begin
      w_rdata = 32'(w_pend);
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_chan_space && (w_chan == 4'(i))) begin
          case (w_reg)
            REG_CTRL:    w_rdata = w_ctrl_rd[i];
            REG_COMPARE: w_rdata = w_compare_rd[i];
            REG_COUNTER: w_rdata = w_counter_rd[i];
            REG_RSVD:    w_rdata = '0;
            default:     w_rdata = '0;
          endcase
        end
      end
    end
  end

  // Read data is captured with the ack so it stays stable for the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= w_access;
      wb_dat_o <= w_access ? w_rdata : 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_mtimer.sv
// ----------------------------------------------------------------------------
// tb_wb_mtimer : random bus traffic against a behavioural timer model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_mtimer;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int PS = 3;
  localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   adr = '0;
  logic [31:0]   dat = '0;
  logic [31:0]   rdat;
  logic [3:0]    sel = '0;
  logic          stb = 1'b0;
  logic          cyc = 1'b0;
  logic          we  = 1'b0;
  logic          ack;
  logic [CH-1:0] intr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mtimer #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .PRESCALE (PS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_dat_o (rdat),
    .wb_sel_i (sel),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_we_i  (we),
    .wb_ack_o (ack),
    .intr     (intr)
  );

  // Reference model state
  bit          m_valid = 0;
  bit          m_ack   = 0;
  int unsigned m_cycle = 0;
  bit          m_en   [CH];
  bit          m_ar   [CH];
  bit          m_ie   [CH];
  bit          m_pend [CH];
  logic [31:0] m_cmp  [CH];
  logic [31:0] m_cnt  [CH];

  typedef struct {
    bit          rd;
    logic [31:0] adr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    logic [31:0] v;
    v = 0;
    if (a[8]) begin
      if (a[7:2] == 0)
        for (int i = 0; i < CH; i++) v[i] = m_pend[i];
    end else begin
      n = int'(a[7:4]);
      if (n < CH) begin
        case (a[3:2])
          2'd0: v = {27'd0, m_pend[n], 1'b0, m_ie[n], m_ar[n], m_en[n]};
          2'd1: v = m_cmp[n];
          2'd2: v = m_cnt[n];
          default: v = 0;
        endcase
      end
    end
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit   acc, wr, tick, chan_hit, stat_hit, set_p, clr_p;
    int   n;
    logic [1:0]  rg;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_en[i] = 0; m_ar[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
        m_cmp[i] = 0; m_cnt[i] = 0;
      end
      m_cycle = 0;
      m_ack   = 0;
      exp_q.delete();
      m_valid = 1;
    end else if (m_valid) begin
      acc = cyc && stb && !m_ack;
      if (acc) begin
        e.rd = !we; e.adr = adr; e.data = model_read(adr);
        exp_q.push_back(e);
      end
      wr       = acc && we && (sel == 4'hF);
      tick     = (m_cycle % PS) == PS - 1;
      m_cycle++;
      n        = int'(adr[7:4]);
      rg       = adr[3:2];
      chan_hit = !adr[8] && n < CH;
      stat_hit = adr[8] && adr[7:2] == 0;
      for (int i = 0; i < CH; i++) begin
        set_p = 0;
        clr_p = 0;
        if (tick && m_en[i]) begin
          if (m_cnt[i] == m_cmp[i]) begin
            set_p = 1;
            if (m_ar[i]) m_cnt[i] = 0;
            else         m_en[i]  = 0;
          end else begin
            m_cnt[i] = (m_cnt[i] + 1) & MASK;
          end
        end
        if (wr && chan_hit && n == i) begin
          case (rg)
            2'd0: begin
              m_en[i] = dat[0]; m_ar[i] = dat[1]; m_ie[i] = dat[2];
              if (dat[3]) m_cnt[i] = 0;
              clr_p = dat[4];
            end
            2'd1: m_cmp[i] = dat & MASK;
            2'd2: m_cnt[i] = dat & MASK;
            default: ;
          endcase
        end
        if (wr && stat_hit && dat[i]) clr_p = 1;
        if (set_p)      m_pend[i] = 1;
        else if (clr_p) m_pend[i] = 0;
      end
      m_ack = acc;
    end
  end

  // Monitor: compares ack, popped read data and interrupt lines every cycle
  always @(negedge clk) begin : monitor
    logic [CH-1:0] ei;
    exp_t e;
    if (m_valid) begin
      checks++;
      if (ack !== m_ack) begin
        errors++;
        $display("FAIL ack t=%0t got=%b exp=%b", $time, ack, m_ack);
      end
      if (m_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e.rd) begin
            checks++;
            if (rdat !== e.data) begin
              errors++;
              $display("FAIL rdata adr=%h got=%h exp=%h t=%0t", e.adr, rdat, e.data, $time);
            end
          end
        end
      end
      for (int i = 0; i < CH; i++) ei[i] = m_pend[i] & m_ie[i];
      checks++;
      if (intr !== ei) begin
        errors++;
        $display("FAIL intr t=%0t got=%b exp=%b", $time, intr, ei);
      end
    end
  end

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    bit got;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    got = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (ack) got = 1;
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout adr=%h got=no_ack exp=ack", a);
    end
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    bus(1, a, d, 4'hF);
  endtask

  task automatic rd32(input logic [31:0] a);
    bus(0, a, 32'd0, 4'hF);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  // Strobe held for several cycles: acks must appear on alternate cycles only
  task automatic burst_read(input logic [31:0] a, input int n);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
    repeat (n) @(negedge clk);
    cyc = 0; stb = 0;
  endtask

  initial begin
    int op, ch;
    logic [31:0] d, a;
    do_reset();

    for (int c = 0; c < CH; c++)
      for (int r = 0; r < 4; r++) rd32(32'(c * 16 + r * 4));
    rd32(32'h100);
    rd32(32'h0F0);

    // Auto-reload with interrupt, then status W1C
    wr32(32'h004, 32'd5);
    wr32(32'h000, 32'h7);
    idle(30);
    rd32(32'h008);
    wr32(32'h100, 32'h1);

    // One-shot on ch1
    wr32(32'h014, 32'd3);
    wr32(32'h010, 32'h5);
    idle(20);
    rd32(32'h010);
    rd32(32'h018);
    wr32(32'h100, 32'h2);

    // Wrap through 2^WIDTH on ch2
    wr32(32'h028, 32'hFE);
    wr32(32'h024, 32'h01);
    wr32(32'h020, 32'h1);
    for (int k = 0; k < 5; k++) rd32(32'h028);
    wr32(32'h024, 32'hFFFF_FF10);
    rd32(32'h024);

    // Byte-select write discarded; unmapped reads
    bus(1, 32'h024, 32'h55, 4'h1);
    rd32(32'h024);
    rd32(32'h0F0);
    rd32(32'h104);

    // Match on every tick while status is repeatedly cleared
    wr32(32'h004, 32'd0);
    wr32(32'h000, 32'h0F);
    for (int k = 0; k < 8; k++) wr32(32'h100, 32'h7);
    burst_read(32'h008, 5);

    // Reset while an ack is pending
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h008; sel = 4'hF;
    @(negedge clk);
    rst = 1; cyc = 0; stb = 0;
    @(negedge clk);
    rst = 0;
    rd32(32'h000);
    rd32(32'h008);

    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 99));
      ch = int'($urandom_range(0, CH));
      a  = 32'(ch * 16);
      if (op < 20) begin
        d = $urandom;
        d[0] = ($urandom_range(0, 3) != 0);
        d[3] = ($urandom_range(0, 3) == 0);
        wr32(a, d);
      end else if (op < 35) begin
        d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
        wr32(a + 4, d);
      end else if (op < 45) begin
        d = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(250, 255));
        wr32(a + 8, d);
      end else if (op < 55) begin
        wr32(32'h100, $urandom);
      end else if (op < 80) begin
        rd32(a + 32'($urandom_range(0, 3) * 4));
      end else if (op < 85) begin
        rd32(32'h100 + 32'($urandom_range(0, 63) * 4));
      end else if (op < 90) begin
        bus(1, a + 32'($urandom_range(0, 2) * 4), $urandom, 4'($urandom_range(0, 14)));
      end else if (op < 93) begin
        burst_read(a + 32'($urandom_range(0, 3) * 4), int'($urandom_range(2, 6)));
      end else if (op < 95) begin
        do_reset();
      end else begin
        idle(int'($urandom_range(5, 40)));
      end
      idle(int'($urandom_range(0, 4)));
    end

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
